// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Looked up combinationally from IF, updated from EX, with branch/mispredict counters.
module branch_target_buffer #(
  parameter int IDX_W = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic        PredictedF,
  output logic [31:0] PredictedTargetF,
  input  logic        BrInstE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        BranchPredictedE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  entry_t           ent_f, ent_e, wr_entry;
  logic             hit_f, hit_e, upd, wr_en;

  // Instructions are word aligned, so the byte-offset bits never take part.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // Lookup reads pre-update contents; there is deliberately no write bypass.
  assign ent_f            = btb_q[idx_f];
  assign hit_f            = ent_f.valid && (ent_f.tag == tag_f);
  assign PredictedF       = hit_f && ent_f.ctr[1];
  assign PredictedTargetF = hit_f ? ent_f.target : 32'h0;

  assign ent_e = btb_q[idx_e];
  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);
  assign upd   = BrInstE && !StallE;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    wr_en    = 1'b0;
    wr_entry = ent_e;
    if (upd) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (BranchE) begin
          if (ent_e.ctr != 2'b11) wr_entry.ctr = ent_e.ctr + 2'b01;
          wr_entry.target = BranchTargetE;
        end else if (ent_e.ctr != 2'b00) begin
          wr_entry.ctr = ent_e.ctr - 2'b01;
        end
      end else if (BranchE) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: tag_e, target: BranchTargetE, ctr: 2'b10};
      end
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      // NOTE: the whole array is reset because lookups must miss immediately after reset;
      // this forces flops rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (wr_en) begin
      // NOTE: state registers use non-blocking assignment so all flops sample the same edge.
      btb_q[idx_e] <= wr_entry;
    end
  end

  // Performance counters saturate instead of wrapping.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      BranchCount     <= 32'h0;
      MispredictCount <= 32'h0;
    end else if (upd) begin
      if (BranchCount != 32'hFFFF_FFFF) BranchCount <= BranchCount + 32'd1;
      if ((BranchPredictedE ^ BranchE) && (MispredictCount != 32'hFFFF_FFFF))
        MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_branch_target_buffer;

  localparam int IDX_W   = 6;
  localparam int ENTRIES = 1 << IDX_W;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N = 1'b0;
  logic [31:0] PCF;
  logic        PredictedF;
  logic [31:0] PredictedTargetF;
  logic        BrInstE;
  logic        StallE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        BranchPredictedE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int checks = 0;
  int fails  = 0;

  branch_target_buffer #(.IDX_W(IDX_W)) dut (
    .CPU_CLK          (CPU_CLK),
    .CPU_RST_N        (CPU_RST_N),
    .PCF              (PCF),
    .PredictedF       (PredictedF),
    .PredictedTargetF (PredictedTargetF),
    .BrInstE          (BrInstE),
    .StallE           (StallE),
    .PCE              (PCE),
    .BranchE          (BranchE),
    .BranchTargetE    (BranchTargetE),
    .BranchPredictedE (BranchPredictedE),
    .BranchCount      (BranchCount),
    .MispredictCount  (MispredictCount)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the full PC that owns it.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_bc, m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && ((m_pc[slot(pc)] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  always @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_pc[i]    <= 32'h0;
        m_tgt[i]   <= 32'h0;
        m_ctr[i]   <= 0;
      end
      m_bc <= 0;
      m_mc <= 0;
    end else if (BrInstE && !StallE) begin
      if (m_bc < 64'hFFFF_FFFF) m_bc <= m_bc + 1;
      if ((BranchPredictedE != BranchE) && (m_mc < 64'hFFFF_FFFF)) m_mc <= m_mc + 1;
      if (m_hit(PCE)) begin
        if (BranchE) begin
          m_ctr[slot(PCE)] <= (m_ctr[slot(PCE)] >= 3) ? 3 : m_ctr[slot(PCE)] + 1;
          m_tgt[slot(PCE)] <= BranchTargetE;
        end else begin
          m_ctr[slot(PCE)] <= (m_ctr[slot(PCE)] <= 0) ? 0 : m_ctr[slot(PCE)] - 1;
        end
      end else if (BranchE) begin
        m_valid[slot(PCE)] <= 1'b1;
        m_pc[slot(PCE)]    <= PCE;
        m_tgt[slot(PCE)]   <= BranchTargetE;
        m_ctr[slot(PCE)]   <= 2;
      end
    end
  end

  // Compare process: outputs are combinational, so check mid-cycle every cycle.
  always @(negedge CPU_CLK) begin
    check("model_pred", {31'b0, PredictedF},
          {31'b0, (m_hit(PCF) && m_ctr[slot(PCF)] >= 2)});
    check("model_target", PredictedTargetF, m_hit(PCF) ? m_tgt[slot(PCF)] : 32'h0);
    check("model_branch_count", BranchCount, m_bc[31:0]);
    check("model_mispredict_count", MispredictCount, m_mc[31:0]);
  end

  task automatic upd(input logic [31:0] pce, input logic taken, input logic [31:0] tgt,
                     input logic pred);
    PCE              = pce;
    BranchE          = taken;
    BranchTargetE    = tgt;
    BranchPredictedE = pred;
    BrInstE          = 1'b1;
    StallE           = 1'b0;
    @(posedge CPU_CLK);
    #1;
    BrInstE = 1'b0;
  endtask

  task automatic expect_lookup(input string name, input logic [31:0] pc, input logic pred,
                               input logic [31:0] tgt);
    PCF = pc;
    #1;
    check({name, "_pred"}, {31'b0, PredictedF}, {31'b0, pred});
    check({name, "_target"}, PredictedTargetF, tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return {$urandom} & 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    PCF = 32'h100; BrInstE = 1'b0; StallE = 1'b0; PCE = 32'h0;
    BranchE = 1'b0; BranchTargetE = 32'h0; BranchPredictedE = 1'b0;

    #3;
    expect_lookup("reset_lookup", 32'h100, 1'b0, 32'h0);
    check("reset_branch_count", BranchCount, 32'h0);
    check("reset_mispredict_count", MispredictCount, 32'h0);
    #8 CPU_RST_N = 1'b1;
    @(posedge CPU_CLK); #1;
    expect_lookup("post_reset_lookup", 32'h100, 1'b0, 32'h0);

    // Allocate 0x100 -> 0x80, weakly taken.
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    expect_lookup("alloc", 32'h100, 1'b1, 32'h80);
    check("alloc_branch_count", BranchCount, 32'd1);
    check("alloc_mispredict_count", MispredictCount, 32'd1);

    // Hysteresis: ctr 2 -> 1 keeps the target, then saturate at 3.
    upd(32'h100, 1'b0, 32'hDEAD_BEEC, 1'b1);
    expect_lookup("nt_from_weak", 32'h100, 1'b0, 32'h80);
    repeat (3) upd(32'h100, 1'b1, 32'h80, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    expect_lookup("sat_then_nt1", 32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    expect_lookup("sat_then_nt2", 32'h100, 1'b0, 32'h80);
    check("hyst_branch_count", BranchCount, 32'd7);
    check("hyst_mispredict_count", MispredictCount, 32'd4);

    // Alias in slot 0 evicts 0x100.
    expect_lookup("alias_miss", 32'h200, 1'b0, 32'h0);
    upd(32'h200, 1'b1, 32'h40, 1'b0);
    expect_lookup("alias_hit", 32'h200, 1'b1, 32'h40);
    expect_lookup("evicted", 32'h100, 1'b0, 32'h0);

    // Stall: a held branch updates exactly once, on release.
    PCE = 32'h300; BranchE = 1'b1; BranchTargetE = 32'h60; BranchPredictedE = 1'b0;
    BrInstE = 1'b1; StallE = 1'b1;
    repeat (3) begin
      expect_lookup("stalled_lookup", 32'h300, 1'b0, 32'h0);
      @(posedge CPU_CLK); #1;
    end
    check("stalled_branch_count", BranchCount, 32'd8);
    StallE = 1'b0;
    expect_lookup("release_same_cycle", 32'h300, 1'b0, 32'h0);
    @(posedge CPU_CLK); #1;
    BrInstE = 1'b0;
    expect_lookup("after_release", 32'h300, 1'b1, 32'h60);
    check("release_branch_count", BranchCount, 32'd9);
    check("release_mispredict_count", MispredictCount, 32'd6);

    // Asynchronous reset between edges while an update is pending.
    PCF = 32'h300; PCE = 32'h400; BranchE = 1'b1; BranchTargetE = 32'h44;
    BranchPredictedE = 1'b0; BrInstE = 1'b1;
    #2 CPU_RST_N = 1'b0;
    expect_lookup("async_reset", 32'h300, 1'b0, 32'h0);
    check("async_reset_branch_count", BranchCount, 32'h0);
    check("async_reset_mispredict_count", MispredictCount, 32'h0);
    @(posedge CPU_CLK); #1;
    BrInstE = 1'b0;
    #2 CPU_RST_N = 1'b1;
    @(posedge CPU_CLK); #1;
    expect_lookup("discarded_alloc", 32'h400, 1'b0, 32'h0);
    check("discarded_branch_count", BranchCount, 32'h0);

    // Randomized traffic with heavy aliasing; the compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      PCE              = rand_pc();
      PCF              = ($urandom_range(0, 3) == 0) ? PCE : rand_pc();
      BrInstE          = $urandom_range(0, 1) == 1;
      StallE           = $urandom_range(0, 3) == 0;
      BranchE          = $urandom_range(0, 1) == 1;
      BranchTargetE    = {$urandom} & 32'hFFFF_FFFC;
      BranchPredictedE = $urandom_range(0, 1) == 1;
      @(posedge CPU_CLK); #1;
    end
    BrInstE = 1'b0;
    @(posedge CPU_CLK); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
